// File: rtl/cnt_sched_pkg.sv
// Shared types and default sizing for the counter scheduler.
package cnt_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int CW_DEF    = 4;

endpackage

// File: rtl/sync_clr_counter.sv
// CW-bit up-counter with enable and synchronous clear; clear wins over enable.
module sync_clr_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cnt_sched.sv
// Round-robin scheduler granting one requester at a time a shared counter
// that runs from 0 up to that requester's latched terminal count.
//
//   state | meaning
//   IDLE  | no grant; counter held at 0; arbitrate among req
//   COUNT | one-hot grant active; counter advancing toward len_lat
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] len,
    input  logic                abort,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
    output logic [CW-1:0]       cnt
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [CW-1:0]    len_lat_q, len_lat_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    cur_q, cur_d;
    logic             cnt_en;
    logic             cnt_clr;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [CW-1:0]    len_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_len
        assign len_arr[g] = len[g*CW +: CW];
    end

    sync_clr_counter #(.CW(CW)) u_cnt (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .en      (cnt_en),
        .clr     (cnt_clr),
        .cnt     (cnt)
    );

    // Search starts one past the last served requester.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        win_vld  = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(last_q) + k) % N_REQ;
            cand_idx = IW'(cand);
            if (!win_vld && req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        len_lat_d = len_lat_q;
        last_d    = last_q;
        cur_d     = cur_q;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (win_vld) begin
                    state_d          = COUNT;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    len_lat_d        = len_arr[win_idx];
                    cur_d            = win_idx;
                end
            end
            COUNT: begin
                // Abort takes priority over a coincident terminal count.
                if (abort) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = cur_q;
                    cnt_clr = 1'b1;
                end else if (cnt == len_lat_q) begin
                    state_d       = IDLE;
                    gnt_d         = '0;
                    done_d[cur_q] = 1'b1;
                    last_d        = cur_q;
                    cnt_clr       = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            len_lat_q <= '0;
            last_q    <= LAST_RST;
            cur_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            len_lat_q <= len_lat_d;
            last_q    <= last_d;
            cur_q     <= cur_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched: hand-computed expectations checked with immediate assertions.
module tb_cnt_sched;

    logic        clk;
    logic        i_rst_n;
    logic [3:0]  req;
    logic [15:0] len;
    logic        abort;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  cnt;

    int checks = 0;
    int errors = 0;

    cnt_sched #(.N_REQ(4), .CW(4)) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .req     (req),
        .len     (len),
        .abort   (abort),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cnt     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [3:0] ed,
                           input logic [3:0] ec, input logic eb);
        chk({tag, ".gnt"},  32'(gnt),  32'(eg));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".cnt"},  32'(cnt),  32'(ec));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic pulse_reset();
        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] seq [5];
        i_rst_n = 1'b0;
        req     = 4'b0000;
        len     = 16'h0000;
        abort   = 1'b0;
        #12;
        chk_out("reset", 4'b0000, 4'b0000, 4'd0, 1'b0);
        i_rst_n = 1'b1;

        // Single requester 0, len0=3
        req = 4'b0001;
        len[3:0] = 4'd3;
        step();
        chk_out("t1.c0", 4'b0001, 4'b0000, 4'd0, 1'b1);
        req = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_out($sformatf("t1.c%0d", k), 4'b0001, 4'b0000, 4'(k), 1'b1);
        end
        step();
        chk_out("t1.done", 4'b0000, 4'b0001, 4'd0, 1'b0);
        step();
        chk_out("t1.after", 4'b0000, 4'b0000, 4'd0, 1'b0);

        // All requesting with zero length, fresh from reset
        pulse_reset();
        len = 16'h0000;
        req = 4'b1111;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out($sformatf("t2.g%0d", k), seq[k], 4'b0000, 4'd0, 1'b1);
            if (k == 4) req = 4'b0000;
            step();
            chk_out($sformatf("t2.i%0d", k), 4'b0000, seq[k], 4'd0, 1'b0);
        end
        step();
        chk_out("t2.quiet", 4'b0000, 4'b0000, 4'd0, 1'b0);

        // Maximum length on requester 2
        req = 4'b0100;
        len[11:8] = 4'd15;
        step();
        chk_out("t3.c0", 4'b0100, 4'b0000, 4'd0, 1'b1);
        req = 4'b0000;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk_out($sformatf("t3.c%0d", k), 4'b0100, 4'b0000, 4'(k), 1'b1);
        end
        step();
        chk_out("t3.done", 4'b0000, 4'b0100, 4'd0, 1'b0);

        // Abort mid-count; last=2 so requester 0 wins, then 1
        req = 4'b0011;
        len[3:0] = 4'd5;
        len[7:4] = 4'd2;
        step();
        chk_out("t4.c0", 4'b0001, 4'b0000, 4'd0, 1'b1);
        step();
        step();
        chk_out("t4.c2", 4'b0001, 4'b0000, 4'd2, 1'b1);
        abort = 1'b1;
        step();
        chk_out("t4.abort", 4'b0000, 4'b0000, 4'd0, 1'b0);
        abort = 1'b0;
        step();
        chk_out("t4.next", 4'b0010, 4'b0000, 4'd0, 1'b1);
        req = 4'b0000;
        step();
        step();
        chk_out("t4.tc", 4'b0010, 4'b0000, 4'd2, 1'b1);
        abort = 1'b1;
        step();
        chk_out("t4.abort_tc", 4'b0000, 4'b0000, 4'd0, 1'b0);

        // Abort while idle is ignored; last=1 so requester 0 wins
        req = 4'b0001;
        len[3:0] = 4'd9;
        step();
        chk_out("t5.idle_abort", 4'b0001, 4'b0000, 4'd0, 1'b1);
        abort = 1'b0;
        req = 4'b0000;
        for (int k = 1; k <= 5; k++) step();
        chk("t5.cnt5", 32'(cnt), 32'd5);

        // Asynchronous reset mid-count
        i_rst_n = 1'b0;
        #2;
        chk_out("t5.async", 4'b0000, 4'b0000, 4'd0, 1'b0);
        len[3:0] = 4'd6;
        req = 4'b1001;
        i_rst_n = 1'b1;
        step();
        chk_out("t5.first", 4'b0001, 4'b0000, 4'd0, 1'b1);
        req = 4'b0000;
        len[3:0] = 4'd1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_out($sformatf("t6.c%0d", k), 4'b0001, 4'b0000, 4'(k), 1'b1);
        end
        step();
        chk_out("t6.done", 4'b0000, 4'b0001, 4'd0, 1'b0);
        step();
        chk_out("t6.after", 4'b0000, 4'b0000, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt_sched.md
CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the counter.
REQ-002 Parameter CW, default 4: counter and length width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req  input  N_REQ  level request per requester.
REQ-006 Port len  input  N_REQ*CW  terminal count per requester; slice i = len[i*CW +: CW].
REQ-007 Port abort  input  1  terminate current grant early.
REQ-008 Port gnt  output  N_REQ  one-hot grant, registered.
REQ-009 Port done  output  N_REQ  one-cycle completion pulse per requester, registered.
REQ-010 Port busy  output  1  high while a grant is active.
REQ-011 Port cnt  output  CW  current count of the shared counter.

Function
REQ-012 The FSM SHALL have two states: IDLE and COUNT.
REQ-013 In IDLE with any req bit high, the block SHALL select a winner i by round-robin, priority starting at (last+1) mod N_REQ.
REQ-014 On the next edge: state=COUNT, gnt=onehot(i), cnt=0, len slice i latched into len_lat.
REQ-015 In COUNT without abort, cnt SHALL increment by 1 each edge while cnt != len_lat.
REQ-016 In COUNT, the edge where cnt == len_lat SHALL set cnt=0, gnt=0, done[i]=1, last=i, state=IDLE; gnt is therefore high for exactly len_lat+1 cycles.
REQ-017 done SHALL be high for exactly one cycle, the cycle after the final gnt cycle.
REQ-018 Arbitration SHALL be evaluated in the done cycle, giving exactly one gnt-low cycle between back-to-back grants.
REQ-019 len_lat = 0 SHALL give a one-cycle grant; len_lat = 2^CW-1 SHALL reach the maximum value, then clear to 0 synchronously, with no arithmetic wrap.
REQ-020 Grants SHALL be non-preemptive: deasserting req or changing len during COUNT has no effect.
REQ-021 abort high in COUNT SHALL, on the next edge, set cnt=0, gnt=0, state=IDLE, last=i, with no done pulse; abort in IDLE SHALL be ignored.
REQ-022 If abort and cnt == len_lat coincide, abort SHALL win (no done).
REQ-023 busy SHALL equal (state == COUNT), decoded from the state register only.
REQ-024 No signal derived from cnt, gnt or state SHALL drive any asynchronous reset or clock; all counter clears are synchronous.

Reset
REQ-025 i_rst_n low SHALL immediately force state=IDLE, gnt=0, done=0, cnt=0, len_lat=0, last=N_REQ-1.
REQ-026 i_rst_n SHALL be the only signal in any asynchronous sensitivity list; it is never combined with internal terms.
REQ-027 Reset asserted mid-count SHALL abandon the grant without a done pulse.
REQ-028 The first arbitration after reset SHALL favour requester 0.

Structure
REQ-029 Package cnt_sched_pkg SHALL hold the state enum (IDLE, COUNT) and the default N_REQ and CW constants.
REQ-030 The counter SHALL be a sub-module sync_clr_counter (CW-bit, enable plus synchronous clear, async active-low reset); arbitration and FSM stay in cnt_sched.

Verification
REQ-031 Reset, req=0001, len0=3 -> gnt=0001 for 4 cycles, cnt 0,1,2,3; done=0001 next cycle; busy low after.
REQ-032 req=1111, all len=0 -> gnt sequence 0001,0010,0100,1000,0001; each lasts 1 cycle, separated by 1 idle cycle.
REQ-033 req=0100, len2=15 -> cnt 0..15 over 16 gnt cycles, then cnt=0 and done=0100; no extra cycle.
REQ-034 req=0011, len0=5, abort at cnt=2 -> gnt=0 next edge, done stays 0000; next grant = 0010.
REQ-035 i_rst_n low at cnt=5 -> gnt=0 and cnt=0 without waiting for a clock; after release, req=1001 -> 0001 granted first.
REQ-036 len0 changed from 6 to 1 during the grant -> grant still lasts 7 cycles.
